// File: rtl/tmr_fault_monitor.sv
// TMR voter back end: registered valid/ready output stage, windowed disagreement accounting, health FSM.
// Optional feature: define TMR_HOLD_LAST_GOOD_EN to repair unresolved words with their last good value.

`ifdef TMR_HOLD_LAST_GOOD_EN
module tmr_word_lane #(
  parameter int VEC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             err,
  input  logic [VEC_W-1:0] din,
  output logic [VEC_W-1:0] dout
);
  logic [VEC_W-1:0] store;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)            store <= '0;
    else if (load && !err) store <= din;

  assign dout = err ? store : din;
endmodule
`endif

module tmr_fault_monitor #(
  parameter int WINDOW         = 256,
  parameter int DEGRADE_THRESH = 4,
  parameter int FAULT_THRESH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [11:0][15:0]      voted,
  input  logic [11:0]            error_flags,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [11:0][15:0]      out_data,
  output logic [11:0]            out_err_mask,
  output logic [1:0]             health,
  output logic [7:0]             err_count,
  output logic                   fault_irq,
  input  logic                   clear_fault
);
  localparam int NUM_LANES = 12;
  localparam int VEC_W     = 16;
  localparam int WW        = $clog2(WINDOW);

  typedef enum logic [1:0] {NORMAL = 2'b00, DEGRADED = 2'b01, FAULT = 2'b10} state_t;

  typedef struct packed {
    logic [NUM_LANES-1:0][VEC_W-1:0] data;
    logic [NUM_LANES-1:0]            mask;
  } rsp_t;

  state_t                          state, state_nxt;
  logic [WW-1:0]                   win_cnt, win_nxt;
  logic [7:0]                      cnt_nxt, acc_next;
  logic [8:0]                      sum;
  logic [3:0]                      n_err;
  logic                            win_end, accept;
  logic [NUM_LANES-1:0][VEC_W-1:0] fwd_data;
  rsp_t                            rsp_q;

  assign in_ready     = !out_valid || out_ready;
  assign accept       = in_valid && in_ready;
  assign out_data     = rsp_q.data;
  assign out_err_mask = rsp_q.mask;
  assign health       = state;

`ifdef TMR_HOLD_LAST_GOOD_EN
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    tmr_word_lane #(.VEC_W(VEC_W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .load (accept),
      .err  (error_flags[i]),
      .din  (voted[i]),
      .dout (fwd_data[i])
    );
  end
`else
  assign fwd_data = voted;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      rsp_q     <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      rsp_q.data <= fwd_data;
      rsp_q.mask <= error_flags;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= NORMAL;
      err_count <= '0;
      win_cnt   <= '0;
      fault_irq <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_count <= cnt_nxt;
      win_cnt   <= win_nxt;
      fault_irq <= (state_nxt == FAULT) && (state != FAULT);
    end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = err_count;
    win_nxt   = win_cnt;
    n_err     = '0;
    for (int i = 0; i < NUM_LANES; i++) n_err = n_err + 4'(error_flags[i]);
    sum      = {1'b0, err_count} + 9'(n_err);
    acc_next = sum[8] ? 8'hFF : sum[7:0];
    win_end  = (win_cnt == WW'(WINDOW - 1));

    // clear has priority over counting a coincident sample
    if (clear_fault) begin
      if (state == FAULT) state_nxt = NORMAL;
      cnt_nxt = '0;
      win_nxt = '0;
    end else if (accept && state != FAULT) begin
      if (win_end) begin
        cnt_nxt = '0;
        win_nxt = '0;
      end else begin
        cnt_nxt = acc_next;
        win_nxt = win_cnt + 1'b1;
      end
      if (acc_next >= 8'(FAULT_THRESH))
        state_nxt = FAULT;
      else if (state == NORMAL && acc_next >= 8'(DEGRADE_THRESH))
        state_nxt = DEGRADED;
      else if (state == DEGRADED && win_end && acc_next < 8'(DEGRADE_THRESH))
        state_nxt = NORMAL;
    end
  end
endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Randomized + directed bench for tmr_fault_monitor; scoreboard queue fed by a reference model.
module tb_tmr_fault_monitor;
  localparam int WIN = 8;
  localparam int DT  = 4;
  localparam int FT  = 16;

  logic         clk = 0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, fault_irq, clear_fault;
  logic [191:0] voted, out_data;
  logic [11:0]  error_flags, out_err_mask;
  logic [1:0]   health;
  logic [7:0]   err_count;

  tmr_fault_monitor #(.WINDOW(WIN), .DEGRADE_THRESH(DT), .FAULT_THRESH(FT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .voted(voted),
    .error_flags(error_flags), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err_mask(out_err_mask), .health(health),
    .err_count(err_count), .fault_irq(fault_irq), .clear_fault(clear_fault)
  );

  always #5 clk = ~clk;

  typedef struct { logic [191:0] d; logic [11:0] m; } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit        m_ov;
  int        m_h, m_cnt, m_win;
  bit        m_irq;
  bit [15:0] m_lg [12];

  task automatic chk(string name, logic [191:0] act, logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ov = 0; m_h = 0; m_cnt = 0; m_win = 0; m_irq = 0;
      foreach (m_lg[i]) m_lg[i] = '0;
      q.delete();
    end else begin
      bit acc;
      int prev_h, s;
      exp_t e;
      acc = in_valid && (!m_ov || out_ready);
      if (acc) begin
        for (int i = 0; i < 12; i++) begin
`ifdef TMR_HOLD_LAST_GOOD_EN
          if (error_flags[i]) e.d[16*i +: 16] = m_lg[i];
          else begin
            e.d[16*i +: 16] = voted[16*i +: 16];
            m_lg[i] = voted[16*i +: 16];
          end
`else
          e.d[16*i +: 16] = voted[16*i +: 16];
`endif
        end
        e.m = error_flags;
        q.push_back(e);
      end
      m_ov = acc ? 1'b1 : (out_ready ? 1'b0 : m_ov);
      prev_h = m_h;
      if (clear_fault) begin
        if (m_h == 2) m_h = 0;
        m_cnt = 0; m_win = 0;
      end else if (acc && m_h != 2) begin
        s = m_cnt + $countones(error_flags);
        if (s > 255) s = 255;
        m_win++;
        if (s >= FT) m_h = 2;
        else if (m_h == 0 && s >= DT) m_h = 1;
        else if (m_h == 1 && m_win == WIN && s < DT) m_h = 0;
        if (m_win == WIN) begin m_cnt = 0; m_win = 0; end
        else m_cnt = s;
      end
      m_irq = (m_h == 2) && (prev_h != 2);
    end
  end

  // monitor: outputs sampled mid-cycle; a transfer is pending when out_valid && out_ready
  always @(negedge clk) begin
    chk("out_valid", 192'(out_valid), 192'(m_ov));
    chk("in_ready", 192'(in_ready), 192'(!m_ov || out_ready));
    chk("health", 192'(health), 192'(m_h));
    chk("err_count", 192'(err_count), 192'(m_cnt));
    chk("fault_irq", 192'(fault_irq), 192'(m_irq));
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL transfer: got unexpected output %h expected none", out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_err_mask", 192'(out_err_mask), 192'(e.m));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(logic [191:0] d, logic [11:0] f);
    in_valid = 1; voted = d; error_flags = f; out_ready = 1;
    step();
    in_valid = 0;
  endtask

  task automatic pulse_clear();
    clear_fault = 1; step(); clear_fault = 0;
  endtask

  function automatic logic [191:0] rnd192();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [191:0] d;
    rst_n = 0; in_valid = 0; out_ready = 0; clear_fault = 0; voted = '0; error_flags = '0;
    repeat (3) step();
    rst_n = 1; step();

    // passthrough
    for (int k = 1; k <= 3; k++) send(192'(k), 12'h000);
    out_ready = 1; step();

    // backpressure: A held, B stalled, then both delivered in order
    out_ready = 0; in_valid = 1; voted = 192'hA; error_flags = 0; step();
    voted = 192'hB; repeat (3) step();
    out_ready = 1; step();
    in_valid = 0; step(); step();

    // degrade, then fault, freeze, clear
    pulse_clear();
    send(192'h11, 12'h00F); step();
    pulse_clear();
    for (int k = 0; k < 4; k++) send(192'(k), 12'h00F);
    step(); step();
    send(192'h55, 12'h0FF); send(192'h56, 12'h001);
    pulse_clear(); step();

    // window recovery
    pulse_clear();
    send(192'h1, 12'h00F);
    for (int k = 0; k < 7; k++) send(192'(k + 2), 12'h000);
    for (int k = 0; k < 8; k++) send(192'(k + 20), 12'h000);
    step();

    // hold last good on word 2
    d = '0; d[47:32] = 16'h1234; send(d, 12'h000);
    d[47:32] = 16'hDEAD;         send(d, 12'h004);
    step();

    // clear coinciding with an accept
    clear_fault = 1; send(192'h77, 12'hFFF); clear_fault = 0; step();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      in_valid    = ($urandom % 4) != 0;
      out_ready   = ($urandom % 4) != 0;
      clear_fault = ($urandom % 80) == 0;
      voted       = rnd192();
      for (int i = 0; i < 12; i++) error_flags[i] = ($urandom % 12) == 0;
      step();
    end
    in_valid = 0; clear_fault = 0; out_ready = 1; step(); step();

    // reset mid-operation discards held sample
    out_ready = 0; in_valid = 1; voted = rnd192(); error_flags = 12'h003; step();
    in_valid = 0; step();
    rst_n = 0; step(); step();
    rst_n = 1; out_ready = 1; step(); step();

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
